// File: rtl/star_pkg.sv
// Shared types, constants and the box-overlap test for the star bank.
package star_pkg;

   localparam int unsigned COORD_W   = 10;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned SCORE_MAX = 255;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_SCAN = 1'b1;

   // Inclusive box overlap; widened by one bit so sums never wrap.
   function automatic logic aabb_hit(input logic [COORD_W-1:0] cx,
                                     input logic [COORD_W-1:0] cy,
                                     input logic [COORD_W-1:0] sx,
                                     input logic [COORD_W-1:0] sy,
                                     input logic [COORD_W-1:0] cw,
                                     input logic [COORD_W-1:0] sw);
      logic [COORD_W:0] cx_e, cy_e, sx_e, sy_e, cw_e, sw_e;
      cx_e = {1'b0, cx};
      cy_e = {1'b0, cy};
      sx_e = {1'b0, sx};
      sy_e = {1'b0, sy};
      cw_e = {1'b0, cw};
      sw_e = {1'b0, sw};
      return (cx_e <= sx_e + sw_e) && (cx_e + cw_e >= sx_e) &&
             (cy_e <= sy_e + sw_e) && (cy_e + cw_e >= sy_e);
   endfunction

endpackage

// File: rtl/star_bank_if.sv
// Render query bus: the renderer drives an index, the bank answers combinationally.
interface star_bank_if;
   import star_pkg::*;

   logic [IDX_W-1:0]   rd_idx;
   logic [COORD_W-1:0] rd_x;
   logic [COORD_W-1:0] rd_y;
   logic               rd_en;
   logic               rd_vis;

   modport master (output rd_idx, input rd_x, rd_y, rd_en, rd_vis);
   modport slave  (input rd_idx, output rd_x, rd_y, rd_en, rd_vis);
endinterface

// File: rtl/star_respawn_ctr.sv
// Per-star respawn countdown: loaded on collect, decremented once per accepted frame.
module star_respawn_ctr #(
   parameter int unsigned LOAD_VAL = 1
) (
   input  logic sys_clk,
   input  logic RST,
   input  logic load,
   input  logic dec,
   output logic expire
);

   logic [7:0] cnt;

   // Load has priority; load and dec never coincide (scan vs idle).
   always_ff @(posedge sys_clk) begin
      if (RST)
         cnt <= '0;
      else if (load)
         cnt <= 8'(LOAD_VAL);
      else if (dec && (cnt != '0))
         cnt <= cnt - 8'd1;
   end

   // Asserted on the decrement that brings the count to zero.
   assign expire = dec && (cnt == 8'd1);

endmodule

// File: rtl/star_bank.sv
// Star bank: per-frame scan of NUM_STARS collectibles against the character box.
module star_bank
   import star_pkg::*;
#(
   parameter int unsigned                     NUM_STARS      = 4,
   parameter logic [NUM_STARS*COORD_W-1:0]    STAR_X_INIT    = {10'd347, 10'd300, 10'd200, 10'd100},
   parameter logic [NUM_STARS*COORD_W-1:0]    STAR_Y_INIT    = {4{10'd56}},
   parameter int unsigned                     STAR_W         = 12,
   parameter int unsigned                     CHAR_W         = 12,
   parameter int unsigned                     RESPAWN_FRAMES = 0,
   parameter int unsigned                     SCREEN_W       = 640
) (
   input  logic                 sys_clk,
   input  logic                 RST,
   input  logic                 frame_tick,
   input  logic [COORD_W-1:0]   char_X,
   input  logic [COORD_W-1:0]   char_Y,
   input  logic [COORD_W-1:0]   bg_pos,
   star_bank_if.slave           rd,
   output logic [NUM_STARS-1:0] en,
   output logic                 touch,
   output logic [IDX_W-1:0]     touch_idx,
   output logic [7:0]           score,
   output logic                 all_collected,
   output logic                 busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STARS - 1);

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [COORD_W-1:0]   cx, cy;
   logic                 tick_ok;
   logic                 cur_en;
   logic [COORD_W-1:0]   cur_x, cur_y;
   logic                 hit_now;
   logic [NUM_STARS-1:0] respawn_now;

   assign tick_ok       = (state == ST_IDLE) && frame_tick;
   assign busy          = (state == ST_SCAN);
   assign all_collected = ~|en;

   // Scan sequencer: latch the character on an idle tick, then step through the stars.
   always_ff @(posedge sys_clk) begin
      if (RST) begin
         state <= ST_IDLE;
         idx   <= '0;
         cx    <= '0;
         cy    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (frame_tick) begin
               cx    <= char_X;
               cy    <= char_Y;
               idx   <= '0;
               state <= ST_SCAN;
            end
            ST_SCAN: begin
               if (idx == LAST_IDX)
                  state <= ST_IDLE;
               else
                  idx <= idx + IDX_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Select the star under evaluation and test it against the latched character.
   always_comb begin
      cur_en = 1'b0;
      cur_x  = '0;
      cur_y  = '0;
      for (int unsigned k = 0; k < NUM_STARS; k++) begin
         if (idx == IDX_W'(k)) begin
            cur_en = en[k];
            cur_x  = STAR_X_INIT[k*COORD_W +: COORD_W];
            cur_y  = STAR_Y_INIT[k*COORD_W +: COORD_W];
         end
      end
      hit_now = (state == ST_SCAN) && cur_en &&
                aabb_hit(cx, cy, cur_x, cur_y, COORD_W'(CHAR_W), COORD_W'(STAR_W));
   end

   generate
      if (RESPAWN_FRAMES > 0) begin : g_respawn
         for (genvar g = 0; g < NUM_STARS; g++) begin : g_ctr
            star_respawn_ctr #(.LOAD_VAL(RESPAWN_FRAMES)) u_ctr (
               .sys_clk (sys_clk),
               .RST     (RST),
               .load    (hit_now && (idx == IDX_W'(g))),
               .dec     (tick_ok),
               .expire  (respawn_now[g])
            );
         end
      end else begin : g_no_respawn
         assign respawn_now = '0;
      end
   endgenerate

   // Collect bookkeeping: enables, one-cycle touch pulse, saturating score.
   always_ff @(posedge sys_clk) begin
      if (RST) begin
         en        <= '1;
         touch     <= 1'b0;
         touch_idx <= '0;
         score     <= '0;
      end else begin
         touch <= hit_now;
         if (hit_now) begin
            touch_idx <= idx;
            if (score != 8'(SCORE_MAX))
               score <= score + 8'd1;
         end
         for (int unsigned k = 0; k < NUM_STARS; k++) begin
            if (respawn_now[k])
               en[k] <= 1'b1;
            else if (hit_now && (idx == IDX_W'(k)))
               en[k] <= 1'b0;
         end
      end
   end

   // Render port: screen-relative coordinates and visibility for the queried star.
   always_comb begin
      logic [COORD_W-1:0] wx, diff;
      rd.rd_x   = '0;
      rd.rd_y   = '0;
      rd.rd_en  = 1'b0;
      rd.rd_vis = 1'b0;
      wx        = '0;
      diff      = '0;
      for (int unsigned k = 0; k < NUM_STARS; k++) begin
         if (rd.rd_idx == IDX_W'(k)) begin
            wx        = STAR_X_INIT[k*COORD_W +: COORD_W];
            diff      = wx - bg_pos;
            rd.rd_x   = diff;
            rd.rd_y   = STAR_Y_INIT[k*COORD_W +: COORD_W];
            rd.rd_en  = en[k];
            rd.rd_vis = en[k] && (wx >= bg_pos) && ({1'b0, diff} < (COORD_W+1)'(SCREEN_W));
         end
      end
   end

endmodule

// File: tb/tb_star_bank.sv
// Bench for star_bank: two configurations run in lockstep against a frame-level model.
module tb_star_bank;

   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic       RST, frame_tick;
   logic [9:0] char_X, char_Y, bg_pos;
   logic [3:0] en_o   [2];
   logic       touch_o[2];
   logic [3:0] tidx_o [2];
   logic [7:0] score_o[2];
   logic       allc_o [2];
   logic       busy_o [2];

   star_bank_if rif0();
   star_bank_if rif1();

   star_bank #(.NUM_STARS(4), .RESPAWN_FRAMES(0)) dut_a (
      .sys_clk(sys_clk), .RST(RST), .frame_tick(frame_tick),
      .char_X(char_X), .char_Y(char_Y), .bg_pos(bg_pos), .rd(rif0.slave),
      .en(en_o[0]), .touch(touch_o[0]), .touch_idx(tidx_o[0]), .score(score_o[0]),
      .all_collected(allc_o[0]), .busy(busy_o[0]));

   star_bank #(.NUM_STARS(4), .STAR_X_INIT({10'd347, 10'd300, 10'd105, 10'd100}),
               .RESPAWN_FRAMES(3)) dut_b (
      .sys_clk(sys_clk), .RST(RST), .frame_tick(frame_tick),
      .char_X(char_X), .char_Y(char_Y), .bg_pos(bg_pos), .rd(rif1.slave),
      .en(en_o[1]), .touch(touch_o[1]), .touch_idx(tidx_o[1]), .score(score_o[1]),
      .all_collected(allc_o[1]), .busy(busy_o[1]));

   // Reference model: star table, enables, respawn timers and score per configuration.
   int unsigned sx_m   [2][4] = '{'{100, 200, 300, 347}, '{100, 105, 300, 347}};
   int unsigned resp_m [2]    = '{0, 3};
   bit          m_en   [2][4];
   int unsigned m_ctr  [2][4];
   int unsigned m_score[2];
   bit          exp_hit[2][4];
   int          n_tests = 0;
   int          n_fail  = 0;

   function automatic bit overlap(input int unsigned x, y, sx, sy);
      return (x <= sx + 12) && (x + 12 >= sx) && (y <= sy + 12) && (y + 12 >= sy);
   endfunction

   function automatic logic [3:0] men(input int d);
      logic [3:0] e;
      for (int k = 0; k < 4; k++) e[k] = m_en[d][k];
      return e;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_score[d] = 0;
         for (int k = 0; k < 4; k++) begin m_en[d][k] = 1'b1; m_ctr[d][k] = 0; end
      end
   endtask

   // One accepted frame: timers tick first, then every star is tested in index order.
   task automatic model_frame(input int unsigned x, y);
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 4; k++)
            if (m_ctr[d][k] > 0) begin
               m_ctr[d][k]--;
               if (m_ctr[d][k] == 0) m_en[d][k] = 1'b1;
            end
         for (int k = 0; k < 4; k++) begin
            exp_hit[d][k] = m_en[d][k] && overlap(x, y, sx_m[d][k], 56);
            if (exp_hit[d][k]) begin
               m_en[d][k]  = 1'b0;
               m_score[d]  = (m_score[d] < 255) ? m_score[d] + 1 : 255;
               m_ctr[d][k] = resp_m[d];
            end
         end
      end
   endtask

   task automatic apply_reset();
      RST = 1'b1; frame_tick = 1'b0;
      @(posedge sys_clk); @(posedge sys_clk); #1;
      RST = 1'b0;
      model_reset();
   endtask

   // Full frame: tick, then four scan cycles checking each pulse; optional ignored tick.
   task automatic test_frame(input int unsigned x, y, input bit drop, input bit wiggle);
      model_frame(x, y);
      char_X = 10'(x); char_Y = 10'(y); frame_tick = 1'b1;
      @(posedge sys_clk); #1; frame_tick = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (busy_o[d] !== 1'b1) begin
            n_fail++; $display("FAIL busy_start dut%0d got %b want 1", d, busy_o[d]);
         end
      end
      for (int c = 0; c < 4; c++) begin
         if (wiggle) begin char_X = 10'($urandom_range(0, 1023)); char_Y = 10'($urandom_range(0, 1023)); end
         if (drop && c == 3) frame_tick = 1'b1;
         @(posedge sys_clk); #1; frame_tick = 1'b0;
         for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (touch_o[d] !== exp_hit[d][c] || (exp_hit[d][c] && tidx_o[d] !== 4'(c))) begin
               n_fail++;
               $display("FAIL touch dut%0d cyc%0d got touch=%b idx=%0d want touch=%b idx=%0d",
                        d, c, touch_o[d], tidx_o[d], exp_hit[d][c], c);
            end
         end
      end
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (busy_o[d] !== 1'b0 || en_o[d] !== men(d) || score_o[d] !== 8'(m_score[d]) ||
             allc_o[d] !== (men(d) == 4'b0000)) begin
            n_fail++;
            $display("FAIL frame_end dut%0d got busy=%b en=%b score=%0d allc=%b want busy=0 en=%b score=%0d allc=%b",
                     d, busy_o[d], en_o[d], score_o[d], allc_o[d], men(d), m_score[d], men(d) == 4'b0000);
         end
      end
   endtask

   task automatic test_render(input logic [9:0] bg);
      logic [21:0] exp_v, got_v;
      int unsigned sx;
      bg_pos = bg;
      for (int i = 0; i < 16; i++) begin
         rif0.rd_idx = 4'(i); rif1.rd_idx = 4'(i); #1;
         for (int d = 0; d < 2; d++) begin
            exp_v = '0;
            if (i < 4) begin
               sx = sx_m[d][i];
               exp_v = {10'(sx - bg), 10'd56, m_en[d][i],
                        1'(m_en[d][i] && (sx >= bg) && (sx - bg < 640))};
            end
            got_v = d ? {rif1.rd_x, rif1.rd_y, rif1.rd_en, rif1.rd_vis}
                      : {rif0.rd_x, rif0.rd_y, rif0.rd_en, rif0.rd_vis};
            n_tests++;
            if (got_v !== exp_v) begin
               n_fail++;
               $display("FAIL render dut%0d idx%0d bg%0d got %h want %h", d, i, bg, got_v, exp_v);
            end
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (en_o[d] !== 4'b1111 || score_o[d] !== 8'd0 || touch_o[d] !== 1'b0 ||
             tidx_o[d] !== 4'd0 || busy_o[d] !== 1'b0 || allc_o[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset dut%0d got en=%b score=%0d touch=%b idx=%0d busy=%b allc=%b want 1111/0/0/0/0/0",
                     d, en_o[d], score_o[d], touch_o[d], tidx_o[d], busy_o[d], allc_o[d]);
         end
      end
      test_render(10'd0);
   endtask

   task automatic test_single();
      test_frame(347, 56, 1'b0, 1'b0);
      test_frame(347, 56, 1'b0, 1'b0);
   endtask

   task automatic test_edge();
      apply_reset();
      test_frame(288, 50, 1'b0, 1'b0);
      apply_reset();
      test_frame(287, 50, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      test_frame(100, 56, 1'b0, 1'b1);
      n_tests++;
      if (score_o[1] !== 8'd2) begin
         n_fail++; $display("FAIL b2b_score got %0d want 2", score_o[1]);
      end
   endtask

   task automatic test_respawn();
      for (int f = 0; f < 3; f++) test_frame(600, 300, 1'b0, 1'b0);
      n_tests++;
      if (en_o[1][0] !== 1'b1 || en_o[0][0] !== 1'b0) begin
         n_fail++; $display("FAIL respawn_en got b=%b a=%b want b=1 a=0", en_o[1][0], en_o[0][0]);
      end
      test_frame(100, 56, 1'b0, 1'b0);
      n_tests++;
      if (score_o[1] !== 8'd4) begin
         n_fail++; $display("FAIL respawn_score got %0d want 4", score_o[1]);
      end
   endtask

   task automatic test_drop_tick();
      apply_reset();
      test_frame(347, 56, 1'b1, 1'b0);
      test_frame(200, 56, 1'b1, 1'b1);
   endtask

   task automatic test_all_collected();
      apply_reset();
      test_frame(100, 56, 1'b0, 1'b0);
      test_frame(200, 56, 1'b0, 1'b0);
      test_frame(300, 56, 1'b0, 1'b0);
      test_frame(347, 56, 1'b0, 1'b0);
      @(posedge sys_clk); #1;
      n_tests++;
      if (allc_o[0] !== 1'b1 || en_o[0] !== 4'b0000) begin
         n_fail++; $display("FAIL all_collected got allc=%b en=%b want 1/0000", allc_o[0], en_o[0]);
      end
   endtask

   task automatic test_reset_mid_scan();
      char_X = 10'd100; char_Y = 10'd56; frame_tick = 1'b1;
      @(posedge sys_clk); #1; frame_tick = 1'b0;
      @(posedge sys_clk); #1;
      RST = 1'b1;
      @(posedge sys_clk); #1;
      RST = 1'b0;
      model_reset();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (busy_o[d] !== 1'b0 || en_o[d] !== 4'b1111 || score_o[d] !== 8'd0 || touch_o[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_scan dut%0d got busy=%b en=%b score=%0d touch=%b want 0/1111/0/0",
                     d, busy_o[d], en_o[d], score_o[d], touch_o[d]);
         end
      end
   endtask

   task automatic test_saturate();
      apply_reset();
      for (int f = 0; f < 460; f++) test_frame(100, 56, 1'b0, 1'b0);
      n_tests++;
      if (score_o[1] !== 8'd255) begin
         n_fail++; $display("FAIL saturate got %0d want 255", score_o[1]);
      end
   endtask

   task automatic test_visibility();
      apply_reset();
      bg_pos = 10'd400; rif0.rd_idx = 4'd0; #1;
      n_tests++;
      if (rif0.rd_vis !== 1'b0 || rif0.rd_x !== 10'd724) begin
         n_fail++; $display("FAIL vis_bg400 got vis=%b x=%0d want vis=0 x=724", rif0.rd_vis, rif0.rd_x);
      end
      test_render(10'd400);
      test_render(10'd0);
   endtask

   task automatic test_random();
      int xi, yi;
      apply_reset();
      for (int f = 0; f < 80; f++) begin
         if ($urandom_range(0, 19) == 0) apply_reset();
         xi = int'(sx_m[$urandom_range(0, 1)][$urandom_range(0, 3)]) + int'($urandom_range(0, 30)) - 15;
         yi = 56 + int'($urandom_range(0, 30)) - 15;
         if (xi < 0) xi = 0;
         test_frame(xi, yi, ($urandom_range(0, 3) == 0), 1'b1);
         if ((f % 10) == 0) test_render(10'($urandom_range(0, 1023)));
      end
   endtask

   initial begin
      RST = 1'b1; frame_tick = 1'b0; char_X = '0; char_Y = '0; bg_pos = '0;
      rif0.rd_idx = '0; rif1.rd_idx = '0;
      test_reset();
      test_single();
      test_edge();
      test_back_to_back();
      test_respawn();
      test_drop_tick();
      test_all_collected();
      test_reset_mid_scan();
      test_saturate();
      test_visibility();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1);
   end

endmodule
